// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants for 7-segment display blocks: hex segment patterns,
// segment bit order, anode polarity, the digit-slot type, and the display
// buffer layout.
// -----------------------------------------------------------------------------
package display_pkg;

  // Segment bit order: bit 0 = a ... bit 6 = g, active-high.
  localparam int SEG_IDX_A = 0;
  localparam int SEG_IDX_G = 6;
  localparam int SEG_W     = SEG_IDX_G - SEG_IDX_A + 1;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  // Anodes are active-low.
  localparam logic       ANODE_ON   = 1'b0;
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  typedef logic [1:0] slot_t;
  localparam slot_t SLOT_LAST = 2'd3;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  en;
    logic [3:0]  dp;
  } disp_buf_t;

  function automatic logic [3:0] anode_sel(slot_t s);
    logic [3:0] a;
    a    = ANODES_OFF;
    a[s] = ANODE_ON;
    return a;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Combinational hex nibble to 7-segment pattern decoder (active-high segments).
// Ports:
//   i_hex  in  4  hex value 0..F
//   o_seg  out 7  segment pattern, [0]=a ... [6]=g
// -----------------------------------------------------------------------------
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0]       i_hex,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = SEG_0;
    case (i_hex)
      4'h0:    o_seg = SEG_0;
      4'h1:    o_seg = SEG_1;
      4'h2:    o_seg = SEG_2;
      4'h3:    o_seg = SEG_3;
      4'h4:    o_seg = SEG_4;
      4'h5:    o_seg = SEG_5;
      4'h6:    o_seg = SEG_6;
      4'h7:    o_seg = SEG_7;
      4'h8:    o_seg = SEG_8;
      4'h9:    o_seg = SEG_9;
      4'hA:    o_seg = SEG_A;
      4'hB:    o_seg = SEG_B;
      4'hC:    o_seg = SEG_C;
      4'hD:    o_seg = SEG_D;
      4'hE:    o_seg = SEG_E;
      4'hF:    o_seg = SEG_F;
      default: o_seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Multiplexed 4-digit 7-segment scanner. Each digit owns a slot of TICK_DIV
// cycles; the first BLANK_CYCLES of every slot drive all anodes off to stop
// ghosting. New content is staged in a pending buffer and only promoted to the
// active buffer at a frame boundary, so a frame is never torn.
// Ports:
//   clock_50mhz   in   1   clock, rising edge
//   reset         in   1   synchronous, active-high
//   digit_data    in   16  four hex digits, [3:0] = digit 0 (rightmost)
//   digit_enable  in   4   per-digit enable, 0 = blank
//   dp_in         in   4   per-digit decimal point
//   lz_en         in   1   leading-zero suppression (applied live)
//   load          in   1   strobe capturing digit_data/digit_enable/dp_in
//   load_ack      out  1   pulse the cycle after captured data goes active
//   segmentos     out  7   segments, active-high, [0]=a ... [6]=g
//   dp            out  1   decimal point, active-high
//   anodo         out  4   digit select, active-low
// -----------------------------------------------------------------------------
module display_scan_controller
  import display_pkg::*;
#(
  parameter int TICK_DIV     = 50_000,
  parameter int BLANK_CYCLES = 500
)(
  input  logic             clock_50mhz,
  input  logic             reset,
  input  logic [15:0]      digit_data,
  input  logic [3:0]       digit_enable,
  input  logic [3:0]       dp_in,
  input  logic             lz_en,
  input  logic             load,
  output logic             load_ack,
  output logic [SEG_W-1:0] segmentos,
  output logic             dp,
  output logic [3:0]       anodo
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYCLES);

  logic [TW-1:0]    r_tick;
  slot_t            r_slot;
  disp_buf_t        r_pend;
  logic             r_pend_valid;
  disp_buf_t        r_act;
  logic             r_load_ack;
  logic [SEG_W-1:0] r_seg;
  logic             r_dp;
  logic [3:0]       r_anodo;

  logic             w_wrap;
  logic             w_boundary;
  disp_buf_t        w_in_buf;
  logic [3:0]       w_nib;
  logic [SEG_W-1:0] w_seg_hex;
  logic [3:0]       w_lz_mask;
  logic             w_dig_on;

  assign w_wrap     = (r_tick == TICK_LAST);
  assign w_boundary = w_wrap && (r_slot == SLOT_LAST);
  assign w_in_buf   = '{data: digit_data, en: digit_enable, dp: dp_in};
  assign w_nib      = r_act.data[{r_slot, 2'b00} +: 4];

  hex_to_7seg u_hex (
    .i_hex (w_nib),
    .o_seg (w_seg_hex)
  );

  // w_lz_mask[k]: digit k is a leading zero, i.e. it is zero and every enabled
  // digit above it is zero too. Digit 0 always shows.
  always_comb begin
    w_lz_mask = '0;
    for (int k = 1; k < 4; k++) begin
      w_lz_mask[k] = (r_act.data[4*k +: 4] == 4'h0);
      for (int j = k + 1; j < 4; j++) begin
        if (r_act.en[j] && (r_act.data[4*j +: 4] != 4'h0)) w_lz_mask[k] = 1'b0;
      end
    end
  end

  assign w_dig_on = r_act.en[r_slot] && !(lz_en && w_lz_mask[r_slot]);

  always_ff @(posedge clock_50mhz) begin
    if (reset) begin
      r_tick       <= '0;
      r_slot       <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_act        <= '0;
      r_load_ack   <= 1'b0;
      r_seg        <= '0;
      r_dp         <= 1'b0;
      r_anodo      <= ANODES_OFF;
    end else begin
      r_tick <= w_wrap ? '0 : r_tick + TW'(1);
      if (w_wrap) r_slot <= r_slot + slot_t'(1);

      if (load) r_pend <= w_in_buf;

      // A load on the boundary cycle bypasses pending and goes straight live.
      if (w_boundary) begin
        r_pend_valid <= 1'b0;
        if (load)              r_act <= w_in_buf;
        else if (r_pend_valid) r_act <= r_pend;
      end else if (load) begin
        r_pend_valid <= 1'b1;
      end

      r_load_ack <= w_boundary && (load || r_pend_valid);

      if (r_tick < BLANK_END) begin
        r_anodo <= ANODES_OFF;
        r_seg   <= '0;
        r_dp    <= 1'b0;
      end else begin
        r_anodo <= anode_sel(r_slot);
        r_seg   <= w_dig_on ? w_seg_hex : '0;
        // Leading-zero blanking keeps the decimal point; disabled digits do not.
        r_dp    <= r_act.en[r_slot] && r_act.dp[r_slot];
      end
    end
  end

  assign load_ack  = r_load_ack;
  assign segmentos = r_seg;
  assign dp        = r_dp;
  assign anodo     = r_anodo;

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

  localparam int TD = 8;
  localparam int BC = 2;
  localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                       7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                       7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digit_data = '0;
  logic [3:0]  digit_enable = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [6:0]  segmentos;
  logic        dp;
  logic [3:0]  anodo;

  always #5 clk = ~clk;

  display_scan_controller #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .clock_50mhz  (clk),
    .reset        (reset),
    .digit_data   (digit_data),
    .digit_enable (digit_enable),
    .dp_in        (dp_in),
    .lz_en        (lz_en),
    .load         (load),
    .load_ack     (load_ack),
    .segmentos    (segmentos),
    .dp           (dp),
    .anodo        (anodo)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int acks_seen = 0;

  // Reference model: cycle count since reset, buffers as plain variables.
  int          m_cnt = 0;
  logic [15:0] a_data, p_data;
  logic [3:0]  a_en, a_dp, p_en, p_dp;
  logic        p_valid;
  logic        e_ack;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  task automatic model_step();
    int tick, slot, msd;
    logic [3:0] nib;
    logic bnd;
    e_ack = 1'b0; e_an = 4'hF; e_seg = '0; e_dp = 1'b0;
    if (reset) begin
      m_cnt = 0;
      a_data = '0; a_en = '0; a_dp = '0;
      p_data = '0; p_en = '0; p_dp = '0; p_valid = 1'b0;
      return;
    end
    tick = m_cnt % TD;
    slot = (m_cnt / TD) % 4;
    if (tick >= BC) begin
      e_an = 4'b1111 ^ (4'd1 << slot);
      nib  = a_data[slot*4 +: 4];
      msd  = -1;
      for (int k = 0; k < 4; k++)
        if (a_en[k] && a_data[k*4 +: 4] != 4'h0) msd = k;
      if (a_en[slot]) begin
        e_dp  = a_dp[slot];
        e_seg = (lz_en && slot > 0 && slot > msd && nib == 4'h0) ? 7'h00 : HEX7[nib];
      end
    end
    bnd   = (tick == TD - 1) && (slot == 3);
    e_ack = bnd && (load || p_valid);
    if (bnd) begin
      if (load) begin
        a_data = digit_data; a_en = digit_enable; a_dp = dp_in;
      end else if (p_valid) begin
        a_data = p_data; a_en = p_en; a_dp = p_dp;
      end
      p_valid = 1'b0;
    end else if (load) begin
      p_data = digit_data; p_en = digit_enable; p_dp = dp_in; p_valid = 1'b1;
    end
    m_cnt++;
  endtask

  task automatic check();
    n_cmp++;
    assert (load_ack === e_ack) else begin
      n_bad++; $error("FAIL load_ack t=%0t got %b exp %b", $time, load_ack, e_ack);
    end
    n_cmp++;
    assert (anodo === e_an) else begin
      n_bad++; $error("FAIL anodo t=%0t got %b exp %b", $time, anodo, e_an);
    end
    n_cmp++;
    assert (segmentos === e_seg) else begin
      n_bad++; $error("FAIL segmentos t=%0t got %h exp %h", $time, segmentos, e_seg);
    end
    n_cmp++;
    assert (dp === e_dp) else begin
      n_bad++; $error("FAIL dp t=%0t got %b exp %b", $time, dp, e_dp);
    end
    if (load_ack === 1'b1) acks_seen++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check();
  endtask

  // Advance until the next edge will see the given tick/slot.
  task automatic run_to(input int tick, input int slot);
    int guard = 0;
    while (!((m_cnt % TD) == tick && ((m_cnt / TD) % 4) == slot) && guard <= 64) begin
      cyc();
      guard++;
    end
    n_cmp++;
    assert (guard <= 64) else begin
      n_bad++; $error("FAIL run_to timeout got %0d exp <=64", guard);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p);
    digit_data = d; digit_enable = e; dp_in = p; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic check_acks(input string tag, input int exp);
    n_cmp++;
    assert (acks_seen === exp) else begin
      n_bad++; $error("FAIL %s ack_count got %0d exp %0d", tag, acks_seen, exp);
    end
  endtask

  initial begin
    // Reset held 3 cycles, then one cycle after release.
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // Single load mid-frame, shown from next frame.
    run_to(3, 1);
    acks_seen = 0;
    do_load(16'h1234, 4'hF, 4'h0);
    run_to(7, 3);
    repeat (33) cyc();
    check_acks("single_load", 1);

    // Two loads in one frame: latest wins, one ack.
    run_to(2, 0);
    acks_seen = 0;
    do_load(16'hAAAA, 4'hF, 4'h0);
    repeat (5) cyc();
    do_load(16'h00F0, 4'hF, 4'h0);
    run_to(7, 3);
    repeat (33) cyc();
    check_acks("double_load", 1);

    // Leading-zero suppression on, then off.
    lz_en = 1'b1;
    do_load(16'h0050, 4'hF, 4'b0100);
    run_to(7, 3);
    repeat (33) cyc();
    lz_en = 1'b0;
    repeat (32) cyc();

    // Load on the boundary cycle overrides an older pending value.
    run_to(0, 1);
    do_load(16'h1111, 4'hF, 4'h0);
    run_to(7, 3);
    acks_seen = 0;
    do_load(16'h2222, 4'hF, 4'h3);
    repeat (40) cyc();
    check_acks("boundary_load", 1);

    // Reset mid-slot.
    run_to(5, 2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    acks_seen = 0;
    repeat (40) cyc();
    check_acks("after_reset", 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      for (int n = 0; n < 4; n++)
        digit_data[n*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      digit_enable = 4'($urandom_range(0, 15));
      dp_in        = 4'($urandom_range(0, 15));
      load         = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
      cyc();
      load = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
